// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: word-only memory accesses,
// read-modify-write for byte/half stores, sign/zero extension for sub-word loads.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_err,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic            o_mem_rd_en,
  output logic            o_mem_wr_en,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_ERR,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [15:0]     r_wdataLo;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_memWdata;
  logic [XLEN-1:0] r_respRdata;

  logic            w_accept;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_reqErr;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_loadData;
  logic [XLEN-1:0] w_merged;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    case (i_req_funct3)
      3'b000: w_misaligned = 1'b0;
      3'b001: w_misaligned = i_req_addr[0];
      3'b010: w_misaligned = |i_req_addr[1:0];
      3'b100: w_illegal    = i_req_we;
      3'b101: begin
        w_illegal    = i_req_we;
        w_misaligned = i_req_addr[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_reqErr = w_illegal || (ALIGN_CHECK && w_misaligned);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Error responses skip memory entirely and are presented from ERR itself,
  // giving the one-cycle error latency.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reqErr)                  w_next = S_ERR;
          else if (!i_req_we)            w_next = S_LOAD;
          else if (i_req_funct3 == 3'b010) w_next = S_WRITE;
          else                           w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_ERR:    if (i_resp_ready) w_next = S_IDLE;
      S_RESP:   if (i_resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_loadData = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_loadData = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_loadData = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_loadData = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_loadData = {{(XLEN-16){1'b0}}, w_half};
      default: w_loadData = i_mem_rdata;
    endcase
  end

  // Only SB (funct3 000) and SH (001) reach RMW, so bit 0 picks the lane width.
  always_comb begin
    w_merged = i_mem_rdata;
    if (!r_funct3[0]) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdataLo[7:0];
        2'd1:    w_merged[15:8]  = r_wdataLo[7:0];
        2'd2:    w_merged[23:16] = r_wdataLo[7:0];
        default: w_merged[31:24] = r_wdataLo[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdataLo;
    end else begin
      w_merged[15:0] = r_wdataLo;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_wdataLo   <= '0;
      r_funct3    <= '0;
      r_memWdata  <= '0;
      r_respRdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr      <= i_req_addr;
        r_wdataLo   <= i_req_wdata[15:0];
        r_funct3    <= i_req_funct3;
        r_memWdata  <= i_req_wdata;
        r_respRdata <= '0;
      end
      if (r_state == S_LOAD)   r_respRdata <= w_loadData;
      if (r_state == S_RMW_RD) r_memWdata  <= w_merged;
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
  assign o_resp_err   = (r_state == S_ERR);
  assign o_resp_rdata = r_respRdata;
  assign o_mem_addr   = {r_addr[XLEN-1:2], 2'b00};
  assign o_mem_wdata  = r_memWdata;
  assign o_mem_rd_en  = (r_state == S_LOAD) || (r_state == S_RMW_RD);
  assign o_mem_wr_en  = (r_state == S_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations, then
// randomized traffic checked cycle by cycle against a request-level model.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        reqValid, reqReady, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [2:0]  reqFunct3;
  logic        respValid, respReady, respErr;
  logic [31:0] respRdata;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memRdEn, memWrEn;
  logic [31:0] junkWord = 32'h0;

  logic [31:0] devMem [256];
  logic [31:0] refMem [256];
  int          rdCount = 0;
  int          wrCount = 0;
  int          checks = 0;
  int          failures = 0;
  int          respCount = 0;

  bit          mInFlight = 0;
  int          mAge, mLat;
  bit          mIsLoad, mIsSw, mIsSub, mErr;
  logic [31:0] mRdata, mWordAddr, mWdata;
  logic [31:0] lastRdata;
  logic        lastErr;
  bit          expRv, expRd, expWr;

  load_store_unit #(.XLEN(32), .ALIGN_CHECK(1'b1)) dut (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .i_req_we     (reqWe),
    .i_req_funct3 (reqFunct3),
    .o_resp_valid (respValid),
    .i_resp_ready (respReady),
    .o_resp_rdata (respRdata),
    .o_resp_err   (respErr),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_mem_rd_en  (memRdEn),
    .o_mem_wr_en  (memWrEn),
    .i_mem_rdata  (memRdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns garbage unless the read strobe is up.
  assign memRdata = memRdEn ? devMem[memAddr[9:2]] : junkWord;

  always @(posedge clock) begin
    junkWord <= $urandom;
    if (memRdEn) rdCount <= rdCount + 1;
    if (memWrEn) begin
      devMem[memAddr[9:2]] <= memWdata;
      wrCount <= wrCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Request-level model: decides the whole transaction outcome at accept time.
  task automatic modelAccept();
    logic [31:0] word, v, mask;
    int sb, sh;
    bit illegal, mis;
    sb = 8 * int'(reqAddr[1:0]);
    sh = 16 * int'(reqAddr[1]);
    illegal = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) || (reqFunct3 == 3'b111) ||
              (reqWe && (reqFunct3 == 3'b100 || reqFunct3 == 3'b101));
    mis = ((reqFunct3 == 3'b001 || reqFunct3 == 3'b101) && reqAddr[0]) ||
          ((reqFunct3 == 3'b010) && (reqAddr[1:0] != 2'b00));
    mErr      = illegal || mis;
    mIsLoad   = !reqWe;
    mIsSw     = reqWe && (reqFunct3 == 3'b010);
    mIsSub    = reqWe && (reqFunct3 == 3'b000 || reqFunct3 == 3'b001);
    mLat      = mErr ? 1 : (mIsSub ? 3 : 2);
    mWordAddr = reqAddr & ~32'h3;
    mRdata    = 32'h0;
    mWdata    = 32'h0;
    word      = refMem[reqAddr[9:2]];
    if (!mErr && mIsLoad) begin
      case (reqFunct3)
        3'b000: begin v = (word >> sb) & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
        3'b100: v = (word >> sb) & 32'hFF;
        3'b001: begin v = (word >> sh) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
        3'b101: v = (word >> sh) & 32'hFFFF;
        default: v = word;
      endcase
      mRdata = v;
    end else if (!mErr) begin
      if (mIsSw) mWdata = reqWdata;
      else begin
        mask = (reqFunct3 == 3'b000) ? (32'hFF << sb) : (32'hFFFF << sh);
        mWdata = (word & ~mask) | ((reqWdata << ((reqFunct3 == 3'b000) ? sb : sh)) & mask);
      end
      refMem[reqAddr[9:2]] = mWdata;
    end
    mAge = 0;
    mInFlight = 1;
  endtask

  // Every cycle, compare handshake, strobes and response against the model.
  always @(negedge clock) begin
    if (reset) begin
      mInFlight = 0;
    end else begin
      if (mInFlight) mAge++;
      expRv = mInFlight && (mAge >= mLat);
      expRd = mInFlight && !mErr && (mAge == 1) && (mIsLoad || mIsSub);
      expWr = mInFlight && !mErr && ((mIsSw && mAge == 1) || (mIsSub && mAge == 2));
      checkBit("req_ready", reqReady, !mInFlight);
      checkBit("resp_valid", respValid, expRv);
      checkBit("mem_rd_en", memRdEn, expRd);
      checkBit("mem_wr_en", memWrEn, expWr);
      if (expRd || expWr) checkOutput("mem_addr", memAddr, mWordAddr);
      if (expWr) checkOutput("mem_wdata", memWdata, mWdata);
      if (expRv) begin
        checkOutput("resp_rdata", respRdata, mRdata);
        checkBit("resp_err", respErr, mErr);
        if (respReady) begin
          lastRdata = respRdata;
          lastErr   = respErr;
          respCount++;
          mInFlight = 0;
        end
      end else if (!mInFlight && reqValid) begin
        modelAccept();
      end
    end
  end

  task automatic setWord(input logic [31:0] addr, input logic [31:0] val);
    devMem[addr[9:2]] <= val;
    refMem[addr[9:2]] = val;
  endtask

  task automatic checkResetValues(input string tag);
    checkBit({tag, "_req_ready"}, reqReady, 1'b1);
    checkBit({tag, "_resp_valid"}, respValid, 1'b0);
    checkBit({tag, "_resp_err"}, respErr, 1'b0);
    checkBit({tag, "_rd_en"}, memRdEn, 1'b0);
    checkBit({tag, "_wr_en"}, memWrEn, 1'b0);
    checkOutput({tag, "_resp_rdata"}, respRdata, 32'h0);
    checkOutput({tag, "_mem_addr"}, memAddr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, memWdata, 32'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic [2:0] f3);
    int n;
    reqAddr = addr; reqWdata = wdata; reqWe = we; reqFunct3 = f3; reqValid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!reqReady && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout actual=%0d expected<40", n);
    end
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  // Counts cycles from accept to resp_valid, then lets the handshake complete.
  task automatic waitResp(output int lat);
    lat = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (respValid) break;
      if (lat >= 40) begin
        checks++; failures++;
        $display("[TB] FAIL resp_timeout actual=%0d expected<40", lat);
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int lat, r0, w0, n, mm, r;
    logic [31:0] saved;
    reset = 1'b1; reqValid = 1'b0; reqAddr = '0; reqWdata = '0; reqWe = 1'b0;
    reqFunct3 = '0; respReady = 1'b0;
    for (int i = 0; i < 256; i++) begin
      saved = $urandom;
      devMem[i] <= saved;
      refMem[i] = saved;
    end
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    respReady = 1'b1;

    setWord(32'h100, 32'hDEADBEEF);
    applyStimulus(32'h100, 32'h0, 1'b0, 3'b010);
    waitResp(lat);
    checkOutput("lw_data", lastRdata, 32'hDEADBEEF);
    checkOutput("lw_latency", lat, 32'd2);

    setWord(32'h100, 32'h80FF1234);
    applyStimulus(32'h103, 32'h0, 1'b0, 3'b000);
    waitResp(lat);
    checkOutput("lb_data", lastRdata, 32'hFFFFFF80);
    applyStimulus(32'h103, 32'h0, 1'b0, 3'b100);
    waitResp(lat);
    checkOutput("lbu_data", lastRdata, 32'h00000080);
    applyStimulus(32'h102, 32'h0, 1'b0, 3'b001);
    waitResp(lat);
    checkOutput("lh_data", lastRdata, 32'hFFFF80FF);

    setWord(32'h200, 32'h11223344);
    r0 = rdCount; w0 = wrCount;
    applyStimulus(32'h201, 32'h000000AB, 1'b1, 3'b000);
    waitResp(lat);
    checkOutput("sb_latency", lat, 32'd3);
    checkOutput("sb_rdata", lastRdata, 32'h0);
    checkOutput("sb_mem", devMem[8'h80], 32'h1122AB44);
    checkOutput("sb_reads", rdCount - r0, 32'd1);
    checkOutput("sb_writes", wrCount - w0, 32'd1);

    r0 = rdCount; w0 = wrCount;
    applyStimulus(32'h101, 32'h0000BEEF, 1'b1, 3'b001);
    waitResp(lat);
    checkBit("sh_mis_err", lastErr, 1'b1);
    checkOutput("sh_mis_latency", lat, 32'd1);
    applyStimulus(32'h102, 32'h0, 1'b0, 3'b010);
    waitResp(lat);
    checkBit("lw_mis_err", lastErr, 1'b1);
    checkOutput("lw_mis_rdata", lastRdata, 32'h0);
    applyStimulus(32'h100, 32'h0, 1'b0, 3'b011);
    waitResp(lat);
    checkBit("illegal_err", lastErr, 1'b1);
    checkOutput("err_strobes", (rdCount - r0) + (wrCount - w0), 32'd0);

    applyStimulus(32'h300, 32'hCAFEF00D, 1'b1, 3'b010);
    waitResp(lat);
    checkOutput("sw_latency", lat, 32'd2);
    checkOutput("sw_mem", devMem[8'hC0], 32'hCAFEF00D);
    checkBit("sw_err", lastErr, 1'b0);

    // Back-pressure with a second request already waiting.
    setWord(32'h180, 32'h5A5AA5A5);
    respReady = 1'b0;
    applyStimulus(32'h180, 32'h0, 1'b0, 3'b010);
    n = 0;
    while (!respValid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    reqAddr = 32'h183; reqWe = 1'b0; reqFunct3 = 3'b100; reqValid = 1'b1;
    r0 = rdCount; w0 = wrCount;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkBit("hold_valid", respValid, 1'b1);
      checkOutput("hold_rdata", respRdata, 32'h5A5AA5A5);
      checkBit("hold_req_ready", reqReady, 1'b0);
    end
    @(posedge clock); #1;
    checkOutput("hold_strobes", (rdCount - r0) + (wrCount - w0), 32'd0);
    respReady = 1'b1;
    applyStimulus(32'h183, 32'h0, 1'b0, 3'b100);
    waitResp(lat);
    checkOutput("b2b_lbu", lastRdata, 32'h0000005A);

    // Reset while the SH is in its read phase must abort the write.
    setWord(32'h240, 32'h01020304);
    w0 = wrCount;
    applyStimulus(32'h242, 32'h0000BEEF, 1'b1, 3'b001);
    #2 reset = 1'b1;
    @(negedge clock);
    checkResetValues("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("midrst_writes", wrCount - w0, 32'd0);
    checkOutput("midrst_mem", devMem[8'h90], 32'h01020304);
    refMem[8'h90] = 32'h01020304;

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 4000; c++) begin
      reqValid = ($urandom_range(0, 2) != 0);
      reqAddr = $urandom;
      if ($urandom_range(0, 1) == 1) reqAddr[1:0] = 2'b00;
      reqWe = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 2)       reqFunct3 = 3'b000;
      else if (r < 4)  reqFunct3 = 3'b001;
      else if (r < 6)  reqFunct3 = 3'b010;
      else if (r == 6) reqFunct3 = 3'b100;
      else if (r == 7) reqFunct3 = 3'b101;
      else if (r == 8) reqFunct3 = 3'b011;
      else             reqFunct3 = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b111;
      reqWdata = $urandom;
      respReady = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    reqValid = 1'b0;
    respReady = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    mm = 0;
    for (int i = 0; i < 256; i++) if (devMem[i] !== refMem[i]) mm++;
    checkOutput("mem_image_diffs", mm, 32'd0);
    checkBit("random_responses_seen", respCount > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
